// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM state type and default geometry for the data memory controller.
package dm_pkg;
    localparam int DM_WIDTH = 32;
    localparam int DM_DEPTH = 32;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/dm_array.sv
// dm_array: word storage with one synchronous byte-lane write port and one combinational read port.
module dm_array
    import dm_pkg::*;
#(
    parameter int WIDTH = DM_WIDTH,
    parameter int DEPTH = DM_DEPTH,
    localparam int LANES = WIDTH / 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [LANES-1:0] we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        for (int i = 0; i < LANES; i++)
            if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    assign rdata = mem[raddr];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding request/response controller over dm_array.
// Define DM_BYTE_STRB_EN to honour reqStrb byte lanes on writes; otherwise writes update the full word.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int WIDTH = DM_WIDTH,
    parameter int DEPTH = DM_DEPTH
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               reqValid,
    output logic               reqReady,
    input  logic               reqWrite,
    input  logic [31:0]        reqAddr,
    input  logic [WIDTH-1:0]   reqData,
    input  logic [WIDTH/8-1:0] reqStrb,
    output logic               rspValid,
    input  logic               rspReady,
    output logic [WIDTH-1:0]   rspData,
    output logic               rspErr
);
    localparam int LANES = WIDTH / 8;
    localparam int OFF = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * LANES);

    state_t state, next;
    logic wr, err;
    logic [31:0] addr;
    logic [WIDTH-1:0] data, rd;
    logic [LANES-1:0] lanes, we;
    logic [AW-1:0] idx;

    // Request fields are captured at acceptance so later bus changes cannot disturb the access.
    always_ff @(posedge clock)
        if (reqReady && reqValid) begin
            wr <= reqWrite;
            addr <= reqAddr;
            data <= reqData;
        end

`ifdef DM_BYTE_STRB_EN
    logic [LANES-1:0] strb;
    always_ff @(posedge clock)
        if (reqReady && reqValid) strb <= reqStrb;
    assign lanes = strb;
`else
    logic unused_strb;
    assign unused_strb = ^reqStrb;
    assign lanes = '1;
`endif

    assign err = addr >= LIMIT;
    assign idx = addr[OFF+AW-1:OFF];

    always_comb begin
        next = state;
        reqReady = state == IDLE;
        rspValid = state == RESP;
        we = '0;
        if (state == IDLE && reqValid) next = ACCESS;
        if (state == ACCESS) begin
            next = RESP;
            we = (wr && !err) ? lanes : '0;
        end
        if (state == RESP && rspReady) next = IDLE;
    end

    always_ff @(posedge clock or negedge resetN)
        if (!resetN) begin
            state <= IDLE;
            rspData <= '0;
            rspErr <= 1'b0;
        end else begin
            state <= next;
            if (state == ACCESS) begin
                rspData <= (wr || err) ? '0 : rd;
                rspErr <= err;
            end
        end

    dm_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_array (
        .clk  (clock),
        .we   (we),
        .waddr(idx),
        .wdata(data),
        .raddr(idx),
        .rdata(rd)
    );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench driving a 32x32 and a 64x16 controller from one shared request bus.
module tb_data_mem_ctrl;
    typedef struct packed {logic [63:0] d; logic e;} exp_t;

`ifdef DM_BYTE_STRB_EN
    localparam logic [63:0] STRB_RD = 64'h11BB11DD;
    localparam logic [63:0] ZERO_RD = 64'h11BB11DD;
`else
    localparam logic [63:0] STRB_RD = 64'hAABBCCDD;
    localparam logic [63:0] ZERO_RD = 64'h99999999;
`endif

    logic clock = 1'b0, resetN, sel, reqValid, reqWrite, rspReady;
    logic [31:0] reqAddr;
    logic [63:0] reqData;
    logic [7:0] reqStrb;
    logic a_ready, a_valid, a_err, b_ready, b_valid, b_err;
    logic [31:0] a_data;
    logic [63:0] b_data;
    logic req_ready, rsp_valid, rsp_err;
    logic [63:0] rsp_data;
    exp_t sb[$];
    int vectors = 0, errs = 0;

    always #5 clock = ~clock;

    data_mem_ctrl #(.WIDTH(32), .DEPTH(32)) dut_a (
        .clock(clock), .resetN(resetN), .reqValid(reqValid && !sel), .reqReady(a_ready),
        .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData[31:0]), .reqStrb(reqStrb[3:0]),
        .rspValid(a_valid), .rspReady(rspReady), .rspData(a_data), .rspErr(a_err)
    );

    data_mem_ctrl #(.WIDTH(64), .DEPTH(16)) dut_b (
        .clock(clock), .resetN(resetN), .reqValid(reqValid && sel), .reqReady(b_ready),
        .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData), .reqStrb(reqStrb),
        .rspValid(b_valid), .rspReady(rspReady), .rspData(b_data), .rspErr(b_err)
    );

    assign req_ready = sel ? b_ready : a_ready;
    assign rsp_valid = sel ? b_valid : a_valid;
    assign rsp_err   = sel ? b_err : a_err;
    assign rsp_data  = sel ? b_data : {32'b0, a_data};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is checked against the oldest expectation.
    always @(negedge clock) begin
        exp_t x;
        if (rsp_valid && rspReady) begin
            vectors++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_rsp: got data=%h err=%b with nothing expected", rsp_data, rsp_err);
            end else begin
                x = sb.pop_front();
                if (rsp_data !== x.d || rsp_err !== x.e) begin
                    errs++;
                    $display("FAIL rsp: got data=%h err=%b expected data=%h err=%b", rsp_data, rsp_err, x.d, x.e);
                end
            end
        end
    end

    task automatic xact(input logic wr, input logic [31:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, input logic [63:0] ed, input logic ee, input int hold);
        int n = 0;
        sb.push_back(exp_t'{d: ed, e: ee});
        reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqData = data; reqStrb = strb;
        rspReady = (hold == 0);
        while (!req_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (n == 20) chk("accept_timeout", 1, 0);
        @(posedge clock); #1;
        reqValid = 1'b0; reqWrite = ~wr; reqAddr = ~addr; reqData = ~data; reqStrb = ~strb;
        chk("access_valid", rsp_valid, 0);
        chk("access_ready", req_ready, 0);
        @(posedge clock); #1;
        chk("latency", rsp_valid, 1);
        repeat (hold) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, ed);
            chk("hold_ready", req_ready, 0);
            @(posedge clock); #1;
        end
        rspReady = 1'b1;
        @(posedge clock); #1;
        chk("release", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; sel = 1'b0; reqValid = 1'b0; reqWrite = 1'b0;
        reqAddr = '0; reqData = '0; reqStrb = '0; rspReady = 1'b1;
        repeat (2) @(posedge clock); #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err", rsp_err, 0);
        resetN = 1'b1;
        @(posedge clock); #1;
        // 32-bit word, 32-deep instance
        xact(1, 32'h00, 64'hDEADBEEF, 8'h0F, 0, 0, 0);
        xact(0, 32'h00, 0, 0, 64'hDEADBEEF, 0, 0);
        xact(1, 32'h7C, 64'h44444444, 8'h0F, 0, 0, 0);
        xact(0, 32'h7C, 0, 0, 64'h44444444, 0, 3);
        xact(1, 32'h08, 64'h08080808, 8'h0F, 0, 0, 0);
        xact(0, 32'h80, 0, 0, 0, 1, 0);
        xact(1, 32'hFFFFFFFC, 64'h12345678, 8'h0F, 0, 1, 0);
        xact(0, 32'h7C, 0, 0, 64'h44444444, 0, 0);
        xact(0, 32'h00, 0, 0, 64'hDEADBEEF, 0, 0);
        xact(0, 32'h7E, 0, 0, 64'h44444444, 0, 0);
        xact(1, 32'h04, 64'h11111111, 8'h0F, 0, 0, 0);
        xact(1, 32'h04, 64'hAABBCCDD, 8'h05, 0, 0, 0);
        xact(0, 32'h04, 0, 0, STRB_RD, 0, 0);
        xact(1, 32'h04, 64'h99999999, 8'h00, 0, 0, 0);
        xact(0, 32'h04, 0, 0, ZERO_RD, 0, 0);
        // Reset lands while the write to 0x08 sits in ACCESS.
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h08; reqData = 64'h55555555; reqStrb = 8'hFF;
        @(posedge clock); #1;
        reqValid = 1'b0;
        resetN = 1'b0;
        #1;
        chk("abort_valid", rsp_valid, 0);
        chk("abort_ready", req_ready, 1);
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;
        chk("abort_idle", req_ready, 1);
        xact(0, 32'h08, 0, 0, 64'h08080808, 0, 0);
        // 64-bit word, 16-deep instance
        sel = 1'b1;
        xact(1, 32'h00, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 0, 0);
        xact(0, 32'h00, 0, 0, 64'hDEADBEEFCAFEF00D, 0, 0);
        xact(0, 32'h80, 0, 0, 0, 1, 0);
        xact(1, 32'h80, 64'h1111111111111111, 8'hFF, 0, 1, 0);
        xact(1, 32'h78, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0);
        xact(0, 32'h78, 0, 0, 64'h0123456789ABCDEF, 0, 0);
        xact(0, 32'h7C, 0, 0, 64'h0123456789ABCDEF, 0, 0);
        xact(1, 32'hFFFFFFF8, 64'h2222222222222222, 8'hFF, 0, 1, 0);
        xact(0, 32'h78, 0, 0, 64'h0123456789ABCDEF, 0, 0);
        xact(0, 32'h00, 0, 0, 64'hDEADBEEFCAFEF00D, 0, 0);
        repeat (2) @(posedge clock); #1;
        chk("sb_drained", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter WIDTH, 32: data word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, 32: number of words; SHALL be a power of two and at least 2.
REQ-003 Port clock  input  1  sole clock; all state SHALL change on the rising edge.
REQ-004 Port resetN  input  1  reset, asynchronous and active-low.
REQ-005 Port reqValid  input  1  request present.
REQ-006 Port reqReady  output  1  controller can accept a request.
REQ-007 Port reqWrite  input  1  1 = write, 0 = read.
REQ-008 Port reqAddr  input  32  byte address.
REQ-009 Port reqData  input  WIDTH  write data.
REQ-010 Port reqStrb  input  WIDTH/8  byte-lane write enables.
REQ-011 Port rspValid  output  1  response present.
REQ-012 Port rspReady  input  1  requester accepts the response.
REQ-013 Port rspData  output  WIDTH  read data; 0 for writes and for errors.
REQ-014 Port rspErr  output  1  the address was out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-016 reqReady SHALL be 1 only in IDLE; a request is accepted on a rising edge where reqValid and reqReady are both 1.
REQ-017 On acceptance, the controller SHALL register reqWrite, reqAddr, reqData and reqStrb and move IDLE->ACCESS.
REQ-018 After its single cycle, ACCESS SHALL move to RESP unconditionally.
REQ-019 RESP SHALL hold rspValid=1 with rspData and rspErr stable until the first edge where rspReady=1, then move to IDLE.
REQ-020 The latency from the acceptance edge to rspValid=1 SHALL be exactly 1 cycle.
REQ-021 Accepting back-to-back requests SHALL cost a minimum of 3 cycles per request.
REQ-022 The word index SHALL be reqAddr[log2(WIDTH/8)+log2(DEPTH)-1 : log2(WIDTH/8)]; the low offset bits SHALL be ignored.
REQ-023 An address is out of range when reqAddr >= DEPTH*WIDTH/8.
REQ-024 An out-of-range request SHALL give rspErr=1 and rspData=0, and SHALL NOT modify memory.
REQ-025 A read SHALL capture the selected word into rspData on the edge that leaves ACCESS.
REQ-026 A write SHALL update memory on the edge that leaves ACCESS.
REQ-027 A write response SHALL be rspValid=1, rspData=0 and rspErr=0 or 1 per REQ-024.
REQ-028 Only one request SHALL be outstanding at a time; read-after-write to the same address SHALL return the written data.
REQ-029 reqData, reqAddr and reqStrb changing after acceptance SHALL have no effect on the transaction in flight.
REQ-030 rspReady asserted outside RESP SHALL be ignored.

Reset
REQ-031 While resetN=0: FSM=IDLE, reqReady=1, rspValid=0, rspData=0, rspErr=0.
REQ-032 Memory array contents SHALL NOT be reset; they are loadable by the testbench hierarchical $readmemh into the storage array.
REQ-033 If reset asserts during ACCESS, the pending write SHALL NOT occur and the transaction SHALL be discarded.
REQ-034 If reset asserts during RESP, the response SHALL be dropped.

Configuration
REQ-035 With macro DM_BYTE_STRB_EN defined, a write SHALL update only the byte lanes whose reqStrb bit is 1; all-zero strobes SHALL leave memory unchanged but still give a response.
REQ-036 Without DM_BYTE_STRB_EN, reqStrb SHALL remain a port but be ignored, and every write SHALL update the full word.

Structure
REQ-037 Package dm_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and the default WIDTH/DEPTH constants.
REQ-038 Storage SHALL be a sub-module dm_array with array name mem, one synchronous write port with per-lane enables, and one read port.
REQ-039 The FSM and handshake logic SHALL live in data_mem_ctrl.

Verification
REQ-040 Reset, then read addr 0x00 from a preloaded word 0xDEADBEEF with rspReady=1 -> rspValid 1 cycle after acceptance, rspData=0xDEADBEEF, rspErr=0.
REQ-041 Write 0x44444444 to 0x7C, then read 0x7C -> rspData=0x44444444; hold rspReady=0 for 3 cycles -> rspValid and rspData stay stable and reqReady stays 0.
REQ-042 Read 0x80 and write 0xFFFFFFFC (DEPTH=32, WIDTH=32) -> rspErr=1, rspData=0, memory unchanged.
REQ-043 With DM_BYTE_STRB_EN, word 0x11111111 at 0x04, write 0xAABBCCDD with strobe 4'b0101 -> read returns 0x11BB11DD; without the macro the read returns 0xAABBCCDD.
REQ-044 Drop resetN during ACCESS of a write of 0x55555555 to 0x08 -> rspValid=0, FSM=IDLE, and a subsequent read of 0x08 returns the old value.
REQ-045 Rerun REQ-040 and REQ-042 with WIDTH=64, DEPTH=16 -> index=reqAddr[6:3]; 0x80 is out of range and 0x78 is in range.
